// File: rtl/rf_pkg.sv
// Shared register-file constants and the writeback entry record.
package rf_pkg;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 16;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Dual-push / single-pop circular buffer of writeback entries.
// With RF_WB_COALESCE_EN it also exposes the tail address and a tail-data overwrite port.
module wb_fifo
  import rf_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push0_i,
  input  wb_entry_t                         din0_i,
  input  logic                              push1_i,
  input  wb_entry_t                         din1_i,
  input  logic                              pop_i,
`ifdef RF_WB_COALESCE_EN
  input  logic                              ovr_i,
  input  logic [RF_DATA_W-1:0]              ovr_data_i,
  output logic [RF_ADDR_W-1:0]              tail_addr_o,
`endif
  output wb_entry_t                         head_o,
  output logic [CW-1:0]                     count_o,
  output logic [DEPTH-1:0]                  vld_o,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]   addr_o
);
  wb_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    rptr_q, wptr_q, wptr1;
  logic [CW-1:0]    cnt_q;
  logic [DEPTH-1:0] vld_q;
  logic [1:0]       npush;

  assign npush = {1'b0, push0_i} + {1'b0, push1_i};
  assign wptr1 = wptr_q + PW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      vld_q  <= '0;
    end else begin
      if (pop_i) begin
        vld_q[rptr_q] <= 1'b0;
        rptr_q        <= rptr_q + PW'(1);
      end
      // Pushes after the pop so a full-with-pop-and-push slot ends up valid.
      if (push0_i) vld_q[wptr_q] <= 1'b1;
      if (push1_i) vld_q[wptr1]  <= 1'b1;
      wptr_q <= wptr_q + PW'(npush);
      cnt_q  <= cnt_q + CW'(npush) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push0_i) mem_q[wptr_q] <= din0_i;
    if (push1_i) mem_q[wptr1]  <= din1_i;
`ifdef RF_WB_COALESCE_EN
    if (ovr_i) mem_q[wptr_q - PW'(1)].data <= ovr_data_i;
`endif
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign vld_o   = vld_q;
`ifdef RF_WB_COALESCE_EN
  assign tail_addr_o = mem_q[wptr_q - PW'(1)].addr;
`endif

  always_comb begin
    addr_o = '0;
    for (int i = 0; i < DEPTH; i++) addr_o[i] = mem_q[i].addr;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (int'(cnt_q) + int'(npush) - int'(pop_i)) <= DEPTH);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop_i && cnt_q == '0));
endmodule

// File: rtl/rf_writeback_unit.sv
// Register-file write initiator: arbitrates ALU (A) and load (B) writebacks into an
// in-order FIFO and issues one write per cycle. Optional macro: RF_WB_COALESCE_EN.
module rf_writeback_unit
  import rf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     wr_a_valid,
  input  logic [ADDR_W-1:0]        wr_a_addr,
  input  logic [DATA_W-1:0]        wr_a_data,
  output logic                     wr_a_ready,
  input  logic                     wr_b_valid,
  input  logic [ADDR_W-1:0]        wr_b_addr,
  input  logic [DATA_W-1:0]        wr_b_data,
  output logic                     wr_b_ready,
  output logic [ADDR_W-1:0]        C,
  output logic [DATA_W-1:0]        PC,
  output logic                     RFLd,
  output logic [RF_NUM_REGS-1:0]   pending,
  output logic [$clog2(DEPTH):0]   wb_count
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]                   cnt;
  logic                            acc_a, acc_b, pop;
  logic                            push0, push1;
  wb_entry_t                       ent_a, ent_b, din0, din1, head;
  logic [DEPTH-1:0]                f_vld;
  logic [DEPTH-1:0][RF_ADDR_W-1:0] f_addr;
  logic [ADDR_W-1:0]               c_q;
  logic [DATA_W-1:0]               pc_q;
  logic                            rfld_q;

  // Readiness uses the pre-edge count only; a same-cycle pop earns no credit.
  assign wr_b_ready = cnt < CW'(DEPTH);
  assign wr_a_ready = wr_b_valid ? (cnt <= CW'(DEPTH - 2)) : (cnt < CW'(DEPTH));
  assign acc_a      = wr_a_valid & wr_a_ready;
  assign acc_b      = wr_b_valid & wr_b_ready;
  assign pop        = cnt != '0;
  assign ent_a      = {wr_a_addr, wr_a_data};
  assign ent_b      = {wr_b_addr, wr_b_data};

`ifdef RF_WB_COALESCE_EN
  logic                 same_ab, have1, have2, ovr;
  logic [RF_ADDR_W-1:0] tail_addr;
  wb_entry_t            e1;

  // The load is older, so a same-register pair collapses to one entry carrying A's data.
  assign same_ab = acc_a & acc_b & (wr_a_addr == wr_b_addr);
  assign have1   = acc_a | acc_b;
  assign have2   = acc_a & acc_b & ~same_ab;
  assign e1      = acc_b ? {wr_b_addr, (same_ab ? wr_a_data : wr_b_data)} : ent_a;
  // With one entry the tail is the head being popped this edge, so only count>=2 merges.
  assign ovr     = have1 & (cnt >= CW'(2)) & (tail_addr == e1.addr);
  assign push0   = ovr ? have2 : have1;
  assign din0    = ovr ? ent_a : e1;
  assign push1   = ~ovr & have2;
  assign din1    = ent_a;
`else
  assign push0 = acc_a | acc_b;
  assign din0  = acc_b ? ent_b : ent_a;
  assign push1 = acc_a & acc_b;
  assign din1  = ent_a;
`endif

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst_n      (RSTn),
    .push0_i    (push0),
    .din0_i     (din0),
    .push1_i    (push1),
    .din1_i     (din1),
    .pop_i      (pop),
`ifdef RF_WB_COALESCE_EN
    .ovr_i      (ovr),
    .ovr_data_i (e1.data),
    .tail_addr_o(tail_addr),
`endif
    .head_o     (head),
    .count_o    (cnt),
    .vld_o      (f_vld),
    .addr_o     (f_addr)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      c_q    <= '0;
      pc_q   <= '0;
      rfld_q <= 1'b0;
    end else begin
      rfld_q <= pop;
      if (pop) begin
        c_q  <= head.addr;
        pc_q <= head.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++)
      if (f_vld[i]) pending[f_addr[i]] = 1'b1;
    if (rfld_q) pending[c_q] = 1'b1;
  end

  assign C        = c_q;
  assign PC       = pc_q;
  assign RFLd     = rfld_q;
  assign wb_count = cnt;
endmodule

// File: tb/tb_rf_writeback_unit.sv
// Randomized + directed bench for rf_writeback_unit against a queue-based reference model.
module tb_rf_writeback_unit;
  typedef struct packed { logic [3:0] addr; logic [31:0] data; } ent_t;

  logic        CLK = 1'b0, RSTn = 1'b0;
  logic        wr_a_valid = 1'b0, wr_b_valid = 1'b0;
  logic [3:0]  wr_a_addr = '0, wr_b_addr = '0;
  logic [31:0] wr_a_data = '0, wr_b_data = '0;
  logic        wr_a_ready, wr_b_ready, RFLd;
  logic [3:0]  C;
  logic [31:0] PC;
  logic [15:0] pending;
  logic [2:0]  wb_count;

  rf_writeback_unit dut (
    .CLK(CLK), .RSTn(RSTn),
    .wr_a_valid(wr_a_valid), .wr_a_addr(wr_a_addr), .wr_a_data(wr_a_data), .wr_a_ready(wr_a_ready),
    .wr_b_valid(wr_b_valid), .wr_b_addr(wr_b_addr), .wr_b_data(wr_b_data), .wr_b_ready(wr_b_ready),
    .C(C), .PC(PC), .RFLd(RFLd), .pending(pending), .wb_count(wb_count)
  );

  always #5 CLK = ~CLK;

  // Register file driven by the DUT's write port.
  logic [31:0] dut_rf [16];
  initial for (int i = 0; i < 16; i++) dut_rf[i] = '0;
  always @(posedge CLK) if (RFLd) dut_rf[C] <= PC;

  // Reference model state.
  ent_t        q[$];
  logic        m_rfld = 1'b0;
  logic [3:0]  m_c = '0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_rf [16];
  initial for (int i = 0; i < 16; i++) m_rf[i] = '0;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [15:0] m_pending();
    logic [15:0] p = '0;
    foreach (q[i]) p[q[i].addr] = 1'b1;
    if (m_rfld) p[m_c] = 1'b1;
    return p;
  endfunction

  function automatic void m_push(input logic [3:0] a, input logic [31:0] d);
`ifdef RF_WB_COALESCE_EN
    if (q.size() > 0 && q[$].addr == a) begin
      q[$].data = d;
      return;
    end
`endif
    q.push_back('{addr: a, data: d});
  endfunction

  task automatic check_state();
    chk("RFLd", 32'(RFLd), 32'(m_rfld));
    chk("C", 32'(C), 32'(m_c));
    chk("PC", PC, m_pc);
    chk("pending", 32'(pending), 32'(m_pending()));
    chk("wb_count", 32'(wb_count), q.size());
  endtask

  task automatic cycle(input logic bv, input logic [3:0] ba, input logic [31:0] bd,
                       input logic av, input logic [3:0] aa, input logic [31:0] ad);
    logic rb, ra;
    @(negedge CLK);
    check_state();
    wr_b_valid = bv; wr_b_addr = ba; wr_b_data = bd;
    wr_a_valid = av; wr_a_addr = aa; wr_a_data = ad;
    #1;
    rb = q.size() < 4;
    ra = bv ? (q.size() <= 2) : (q.size() < 4);
    chk("rdyB", 32'(wr_b_ready), 32'(rb));
    chk("rdyA", 32'(wr_a_ready), 32'(ra));
    @(posedge CLK);
    if (m_rfld) m_rf[m_c] = m_pc;
    if (q.size() > 0) begin
      ent_t h = q.pop_front();
      m_c = h.addr; m_pc = h.data; m_rfld = 1'b1;
    end else m_rfld = 1'b0;
    if (bv && rb) m_push(ba, bd);
    if (av && ra) m_push(aa, ad);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic mid_reset();
    @(negedge CLK);
    wr_a_valid = 1'b0; wr_b_valid = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    chk("rst_RFLd", 32'(RFLd), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_count", 32'(wb_count), 32'd0);
    q.delete(); m_rfld = 1'b0; m_c = '0; m_pc = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;
    idle(2);

    // Single ALU write
    cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'd3, 32'd90);
    idle(4);
    chk("rf3", dut_rf[3], 32'd90);

    // Same-register dual push; final value must be A's data
    cycle(1'b1, 4'd5, 32'd73, 1'b1, 4'd5, 32'd16);
    idle(4);
    chk("rf5", dut_rf[5], 32'd16);

    // Continuous dual pushes saturate the buffer
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 4'(2 * i), 32'(200 + i), 1'b1, 4'(2 * i + 1), 32'(300 + i));
    idle(6);

    // Reset with three entries queued
    cycle(1'b1, 4'd7, 32'd1, 1'b1, 4'd8, 32'd2);
    cycle(1'b1, 4'd9, 32'd3, 1'b1, 4'd10, 32'd4);
    mid_reset();
    idle(4);

    // Pointer wrap-around
    for (int r = 0; r < 10; r++) cycle(1'b0, 4'd0, 32'd0, 1'b1, 4'(r), 32'(100 + r));
    idle(4);
    for (int r = 0; r < 10; r++) chk("wrap_rf", dut_rf[r], 32'(100 + r));

    // Random traffic, small address range half the time to hit repeats
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] ba, aa;
      ba = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      aa = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cycle($urandom_range(0, 9) < 6, ba, $urandom, $urandom_range(0, 9) < 6, aa, $urandom);
      if (i == 700) mid_reset();
    end
    idle(8);
    for (int r = 0; r < 16; r++) chk("final_rf", dut_rf[r], m_rf[r]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
